// File: rtl/codec_loopback_master.sv
// Avalon-MM master for the codec register port: runs an I2C configuration table paced on
// i2c_idle, then loops ADC samples back to the DAC until loop_en is released.
module codec_loopback_master #(
    parameter logic [2:0]  ADDR_I2C     = 3'd0,
    parameter logic [2:0]  ADDR_STATUS  = 3'd1,
    parameter logic [2:0]  ADDR_DAC     = 3'd2,
    parameter logic [2:0]  ADDR_ADC     = 3'd3,
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned POLL_TIMEOUT = 1023
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic        loop_en,
    input  logic        mute,
    input  logic [4:0]  init_count,
    output logic [4:0]  init_addr,
    input  logic [23:0] init_data,
    output logic [2:0]  master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic [31:0] master_readdata,
    input  logic        master_waitrequest,
    output logic        busy,
    output logic        init_done,
    output logic        error,
    output logic [15:0] sample_count
);

    localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_TIMEOUT - 1);
    localparam logic [3:0] SettleInit = 4'(SETTLE_CYC);

    typedef enum logic [2:0] {
        StIdle,
        StInitWr,
        StInitSettle,
        StInitPoll,
        StStrmRd,
        StStrmWr
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [4:0]         r_count, w_count_nxt;
    logic [4:0]         r_addr, w_addr_nxt;
    logic [3:0]         r_settle, w_settle_nxt;
    logic [PollW-1:0]   r_poll, w_poll_nxt;
    logic [31:0]        r_sample, w_sample_nxt;
    logic [2:0]         r_bus_addr, w_bus_addr_nxt;
    logic               r_read, w_read_nxt;
    logic               r_write, w_write_nxt;
    logic [31:0]        r_wdata, w_wdata_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;
    logic [15:0]        r_samples, w_samples_nxt;

    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_addr     <= '0;
            r_settle   <= '0;
            r_poll     <= '0;
            r_sample   <= '0;
            r_bus_addr <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_samples  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_addr     <= w_addr_nxt;
            r_settle   <= w_settle_nxt;
            r_poll     <= w_poll_nxt;
            r_sample   <= w_sample_nxt;
            r_bus_addr <= w_bus_addr_nxt;
            r_read     <= w_read_nxt;
            r_write    <= w_write_nxt;
            r_wdata    <= w_wdata_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_samples  <= w_samples_nxt;
        end
    end

    // Each request state spends its first cycle with the request low and raises the
    // registered request from there; the request drops on the completion cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_addr_nxt     = r_addr;
        w_settle_nxt   = r_settle;
        w_poll_nxt     = r_poll;
        w_sample_nxt   = r_sample;
        w_bus_addr_nxt = r_bus_addr;
        w_read_nxt     = r_read;
        w_write_nxt    = r_write;
        w_wdata_nxt    = r_wdata;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_samples_nxt  = r_samples;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_count_nxt   = init_count;
                    w_addr_nxt    = '0;
                    w_samples_nxt = '0;
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b0;
                    if (init_count == 5'd0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StStrmRd;
                    end else begin
                        w_state_nxt = StInitWr;
                    end
                end
            end

            StInitWr: begin
                if (!r_write) begin
                    w_write_nxt    = 1'b1;
                    w_bus_addr_nxt = ADDR_I2C;
                    w_wdata_nxt    = {8'h00, init_data};
                end else if (!master_waitrequest) begin
                    w_write_nxt  = 1'b0;
                    w_settle_nxt = SettleInit;
                    w_state_nxt  = StInitSettle;
                end
            end

            // Gives the slave time to register the write and drop i2c_idle before polling.
            StInitSettle: begin
                if (r_settle <= 4'd1) begin
                    w_poll_nxt  = '0;
                    w_state_nxt = StInitPoll;
                end else begin
                    w_settle_nxt = r_settle - 4'd1;
                end
            end

            StInitPoll: begin
                w_poll_nxt     = r_poll + 1'b1;
                w_read_nxt     = 1'b1;
                w_bus_addr_nxt = ADDR_STATUS;
                if (r_read && !master_waitrequest && master_readdata[0]) begin
                    w_read_nxt = 1'b0;
                    if (r_addr == r_count - 5'd1) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = loop_en ? StStrmRd : StIdle;
                    end else begin
                        w_addr_nxt  = r_addr + 5'd1;
                        w_state_nxt = StInitWr;
                    end
                end else if (r_poll == PollLast) begin
                    w_read_nxt  = 1'b0;
                    w_error_nxt = 1'b1;
                    w_state_nxt = StIdle;
                end
            end

            StStrmRd: begin
                if (!r_read) begin
                    if (!loop_en) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_read_nxt     = 1'b1;
                        w_bus_addr_nxt = ADDR_ADC;
                    end
                end else if (!master_waitrequest) begin
                    w_sample_nxt = master_readdata;
                    w_read_nxt   = 1'b0;
                    w_state_nxt  = StStrmWr;
                end
            end

            // mute is only looked at when the write is launched, so it cannot tear a transfer.
            StStrmWr: begin
                if (!r_write) begin
                    w_write_nxt    = 1'b1;
                    w_bus_addr_nxt = ADDR_DAC;
                    w_wdata_nxt    = mute ? 32'h0 : r_sample;
                end else if (!master_waitrequest) begin
                    w_write_nxt   = 1'b0;
                    w_samples_nxt = r_samples + 16'd1;
                    w_state_nxt   = loop_en ? StStrmRd : StIdle;
                end
            end

            default: begin
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign init_addr        = r_addr;
    assign master_address   = r_bus_addr;
    assign master_read      = r_read;
    assign master_write     = r_write;
    assign master_writedata = r_wdata;
    assign busy             = (r_state != StIdle);
    assign init_done        = r_done;
    assign error            = r_error;
    assign sample_count     = r_samples;

endmodule

// File: tb/tb_codec_loopback_master.sv
// Bench for codec_loopback_master: behavioural codec slave, transaction scoreboard and
// directed scenarios for configuration, loopback, mute, timeout and reset.
module tb_codec_loopback_master;

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic        loop_en;
    logic        mute;
    logic [4:0]  init_count;
    logic [4:0]  init_addr;
    logic [23:0] init_data;
    logic [2:0]  master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        master_waitrequest;
    logic        busy;
    logic        init_done;
    logic        error;
    logic [15:0] sample_count;

    codec_loopback_master dut (
        .Clk                (Clk),
        .Rst_n              (Rst_n),
        .start              (start),
        .loop_en            (loop_en),
        .mute               (mute),
        .init_count         (init_count),
        .init_addr          (init_addr),
        .init_data          (init_data),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_readdata    (master_readdata),
        .master_waitrequest (master_waitrequest),
        .busy               (busy),
        .init_done          (init_done),
        .error              (error),
        .sample_count       (sample_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural codec slave ----------------
    logic [23:0] tbl [32];
    assign init_data = tbl[init_addr];

    logic [31:0] adc_mem [16];
    int          adc_wr = 0;
    int          adc_rd = 0;
    int          adc_stall = 0;
    int          dac_stall = 0;
    int          stall_cnt;
    int          lim;
    logic        i2c_idle;
    int          i2c_tmr;
    logic        i2c_hold_low = 1'b0;
    logic        req;
    logic        adc_empty;

    assign req       = master_read | master_write;
    assign adc_empty = (adc_rd == adc_wr);

    always_comb begin
        lim = 0;
        if (master_read && master_address == 3'd3) lim = adc_stall;
        else if (master_write && master_address == 3'd2) lim = dac_stall;
    end

    assign master_waitrequest = req && ((stall_cnt < lim) ||
                                (master_read && master_address == 3'd3 && adc_empty));

    always_comb begin
        master_readdata = 32'h0;
        if (master_read && master_address == 3'd1)
            master_readdata = {28'h0, adc_empty, 1'b0, 1'b0, i2c_idle};
        else if (master_read && master_address == 3'd3)
            master_readdata = adc_mem[adc_rd[3:0]];
    end

    always @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            stall_cnt <= 0;
            i2c_idle  <= 1'b1;
            i2c_tmr   <= -1;
        end else begin
            if (req && master_waitrequest) stall_cnt <= stall_cnt + 1;
            else stall_cnt <= 0;
            if (master_read && !master_waitrequest && master_address == 3'd3)
                adc_rd <= adc_rd + 1;
            if (master_write && !master_waitrequest && master_address == 3'd0) begin
                i2c_tmr <= 0;
            end else if (i2c_tmr >= 0) begin
                i2c_tmr <= i2c_tmr + 1;
                if (i2c_tmr + 1 == 2) i2c_idle <= 1'b0;
                if (i2c_tmr + 1 >= 42 && !i2c_hold_low) begin
                    i2c_idle <= 1'b1;
                    i2c_tmr  <= -1;
                end
            end
        end
    end

    // ---------------- scoreboard and per-cycle compare ----------------
    logic [23:0] exp_i2c [$];
    logic [31:0] exp_dac [$];
    logic [31:0] dac_log [32];
    int          n_dac = 0;
    int          n_i2c = 0;
    int          stat_cycles = 0;
    logic [15:0] m_cnt = 16'h0;
    logic        idle_seen = 1'b0;
    logic        i2c_first = 1'b0;
    logic        expect_done_next = 1'b0;
    logic        first_pending = 1'b0;
    logic        prev_stall = 1'b0;
    logic [2:0]  p_addr;
    logic        p_rd;
    logic        p_wr;
    logic [31:0] p_wdata;

    always @(negedge Clk) begin
        logic [23:0] e24;
        logic [31:0] e32;
        #2;
        if (Rst_n) begin
            prev_stall    = 1'b0;
            m_cnt         = 16'h0;
            first_pending = 1'b0;
        end else begin
            if (req) check("rd_wr_exclusive", {31'h0, master_read & master_write}, 32'h0);
            check("sample_count", {16'h0, sample_count}, {16'h0, m_cnt});
            if (expect_done_next) begin
                check("init_done_after_start", {31'h0, init_done}, 32'h1);
                expect_done_next = 1'b0;
            end
            if (prev_stall) begin
                check("stall_hold_addr", {29'h0, master_address}, {29'h0, p_addr});
                check("stall_hold_req", {30'h0, master_read, master_write}, {30'h0, p_rd, p_wr});
                check("stall_hold_wdata", master_writedata, p_wdata);
            end
            if (first_pending && req) begin
                check("first_req_adc_read", {27'h0, master_read, master_write, master_address},
                      {27'h0, 1'b1, 1'b0, 3'd3});
                first_pending = 1'b0;
            end
            if (master_read && master_address == 3'd1) stat_cycles++;
            if (req && !master_waitrequest) begin
                if (master_write && master_address == 3'd0) begin
                    check("i2c_write_expected", {31'h0, exp_i2c.size() != 0}, 32'h1);
                    if (exp_i2c.size() != 0) begin
                        e24 = exp_i2c.pop_front();
                        check("i2c_data", master_writedata, {8'h0, e24});
                    end
                    check("i2c_paced_on_idle", {31'h0, i2c_first | idle_seen}, 32'h1);
                    i2c_first = 1'b0;
                    idle_seen = 1'b0;
                    n_i2c++;
                end
                if (master_read && master_address == 3'd1 && master_readdata[0]) idle_seen = 1'b1;
                if (master_write && master_address == 3'd2) begin
                    check("dac_write_expected", {31'h0, exp_dac.size() != 0}, 32'h1);
                    if (exp_dac.size() != 0) begin
                        e32 = exp_dac.pop_front();
                        check("dac_data", master_writedata, e32);
                    end
                    dac_log[n_dac[4:0]] = master_writedata;
                    n_dac++;
                    m_cnt = m_cnt + 16'd1;
                end
            end
            prev_stall = req && master_waitrequest;
            p_addr  = master_address;
            p_rd    = master_read;
            p_wr    = master_write;
            p_wdata = master_writedata;
            if (start && !busy) begin
                m_cnt            = 16'h0;
                idle_seen        = 1'b0;
                i2c_first        = 1'b1;
                expect_done_next = (init_count == 5'd0);
                first_pending    = (init_count == 5'd0) && loop_en;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy(input int max, input string name);
        for (int i = 0; i < max && busy; i++) @(negedge Clk);
        check(name, {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_samples(input logic [15:0] n, input int max, input string name);
        for (int i = 0; i < max && sample_count != n; i++) @(negedge Clk);
        check(name, {16'h0, sample_count}, {16'h0, n});
    endtask

    task automatic wait_adc_read(input int max, input string name);
        for (int i = 0; i < max && !(master_read && master_address == 3'd3); i++) @(negedge Clk);
        check(name, {31'h0, master_read && master_address == 3'd3}, 32'h1);
    endtask

    task automatic push_adc(input logic [31:0] v);
        adc_mem[adc_wr[3:0]] = v;
        adc_wr++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_rd_wr"}, {30'h0, master_read, master_write}, 32'h0);
        check({tag, "_addr_wdata"}, master_writedata | {29'h0, master_address}, 32'h0);
        check({tag, "_flags"}, {30'h0, init_done, error}, 32'h0);
        check({tag, "_counts"}, {11'h0, init_addr, sample_count}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl[i] = 24'h0;
        start = 1'b0;
        loop_en = 1'b0;
        mute = 1'b0;
        init_count = 5'd0;
        Rst_n = 1'b0;
        #1 Rst_n = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(negedge Clk);
        Rst_n = 1'b0;

        // Configuration sequence, loop_en low so the block returns to IDLE.
        tbl[0] = 24'h341E00;
        tbl[1] = 24'h340C00;
        tbl[2] = 24'h340E42;
        exp_i2c.push_back(24'h341E00);
        exp_i2c.push_back(24'h340C00);
        exp_i2c.push_back(24'h340E42);
        init_count = 5'd3;
        pulse_start();
        wait_not_busy(1000, "cfg_busy_fall");
        check("cfg_i2c_writes", n_i2c, 3);
        check("cfg_queue_drained", exp_i2c.size(), 0);
        check("cfg_init_done", {31'h0, init_done}, 32'h1);
        check("cfg_error", {31'h0, error}, 32'h0);
        check("cfg_init_addr", {27'h0, init_addr}, 32'd2);
        check("cfg_no_dac", n_dac, 0);

        // Zero-length init straight into loopback with 5-cycle ADC stalls.
        adc_stall = 5;
        push_adc(32'hA5A5_0001);
        push_adc(32'h1234_5678);
        exp_dac.push_back(32'hA5A5_0001);
        exp_dac.push_back(32'h1234_5678);
        init_count = 5'd0;
        loop_en = 1'b1;
        pulse_start();
        wait_samples(16'd2, 200, "lb_two_samples");
        check("lb_dac0", dac_log[0], 32'hA5A5_0001);
        check("lb_dac1", dac_log[1], 32'h1234_5678);
        check("lb_no_i2c", n_i2c, 3);
        wait_adc_read(50, "lb_third_read");
        loop_en = 1'b0;
        push_adc(32'h0000_0003);
        exp_dac.push_back(32'h0000_0003);
        wait_not_busy(100, "lb_busy_fall");
        check("lb_final_count", {16'h0, sample_count}, 32'd3);

        // Mute on the second sample, loop_en dropped during the third ADC read.
        push_adc(32'h1111_1111);
        push_adc(32'h2222_2222);
        exp_dac.push_back(32'h1111_1111);
        exp_dac.push_back(32'h0000_0000);
        loop_en = 1'b1;
        pulse_start();
        wait_samples(16'd1, 100, "mute_first");
        mute = 1'b1;
        wait_samples(16'd2, 100, "mute_second");
        mute = 1'b0;
        wait_adc_read(50, "mute_third_read");
        loop_en = 1'b0;
        push_adc(32'h3333_3333);
        exp_dac.push_back(32'h3333_3333);
        wait_not_busy(100, "mute_busy_fall");
        check("mute_count", {16'h0, sample_count}, 32'd3);
        check("mute_dac_zero", dac_log[4], 32'h0);
        check("mute_third_written", dac_log[5], 32'h3333_3333);

        // Poll timeout: i2c_idle never returns after the first write.
        i2c_hold_low = 1'b1;
        exp_i2c.push_back(tbl[0]);
        init_count = 5'd2;
        stat_cycles = 0;
        pulse_start();
        wait_not_busy(1500, "to_busy_fall");
        check("to_error", {31'h0, error}, 32'h1);
        check("to_init_done", {31'h0, init_done}, 32'h0);
        check("to_one_write", exp_i2c.size(), 0);
        check("to_poll_cycles", {31'h0, stat_cycles >= 1015 && stat_cycles <= 1030}, 32'h1);
        i2c_hold_low = 1'b0;
        repeat (3) @(negedge Clk);
        init_count = 5'd0;
        pulse_start();
        check("to_error_cleared", {31'h0, error}, 32'h0);
        wait_not_busy(20, "to_restart_idle");

        // Reset while a DAC write is stalled.
        dac_stall = 100000;
        push_adc(32'h0BAD_F00D);
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 50 && !master_write; i++) @(negedge Clk);
        check("rst_write_seen", {31'h0, master_write}, 32'h1);
        #3 Rst_n = 1'b1;
        #1 check_all_zero("rst_async");
        dac_stall = 0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            #1 check("rst_stays_idle", {30'h0, busy, master_read | master_write}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
